// File: rtl/movavg_pkg.sv
// movavg_pkg: constants and helpers shared by the moving-average summer and
// its normalizer, so both stages agree on data width and tap count.
//   WL        : data width of window sums and averages
//   TAP_LOG2  : log2 of the tap count (divide is a right shift by this)
//   TAP_COUNT : number of taps in the window
//   WARMUP    : accepted sums discarded after reset while the window fills
package movavg_pkg;

    localparam int unsigned WL        = 64;
    localparam int unsigned TAP_LOG2  = 2;
    localparam int unsigned TAP_COUNT = 1 << TAP_LOG2;
    localparam int unsigned WARMUP    = TAP_COUNT - 1;

    typedef logic [15:0] drop_cnt_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/movavg_norm_if.sv
// movavg_norm_if: stream signals of the normalizer.
//   sum_in/sum_valid        : window sums from the summer (no backpressure)
//   dout/dout_valid/dout_ready : averaged output with valid/ready handshake
// Modports:
//   master : environment side (drives sums and ready, observes output)
//   slave  : normalizer side
interface movavg_norm_if #(
    parameter int unsigned WL = movavg_pkg::WL
);
    logic [WL-1:0] sum_in;
    logic          sum_valid;
    logic [WL-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;

    modport master (
        output sum_in, sum_valid, dout_ready,
        input  dout, dout_valid
    );

    modport slave (
        input  sum_in, sum_valid, dout_ready,
        output dout, dout_valid
    );
endinterface

// File: rtl/movavg_fifo.sv
// movavg_fifo: DEPTH x WL synchronous FIFO.
//   clk, reset_n : clock, asynchronous active-low reset
//   push_i       : write wdata_i (caller guarantees room, or a same-cycle pop)
//   pop_i        : retire the head entry (caller guarantees non-empty)
//   rdata_o      : head entry, zero while empty
//   full_o       : DEPTH entries held
//   count_o      : occupancy 0..DEPTH
module movavg_fifo #(
    parameter  int unsigned WL    = 64,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [WL-1:0] wdata_i,
    output logic [WL-1:0] rdata_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    logic [WL-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop_i) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CW'(1);
        end
    end

    // On full with push and pop together wptr equals rptr: the head is read
    // out this cycle and its slot is overwritten at the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= wdata_i;
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign rdata_o = (count_q == '0) ? '0 : mem_q[rptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/movavg_norm.sv
// movavg_norm: divides each valid window sum by the tap count (optional
// round-half-up), drops the first WARMUP sums after reset, and buffers the
// averages in a FIFO with a valid/ready output.
//   clk, reset_n : clock, asynchronous active-low reset
//   io (slave)   : sum_in/sum_valid in, dout/dout_valid/dout_ready out
//   drop_flag    : sticky, a sample was lost because the FIFO was full
//   drop_cnt     : saturating count of lost samples
module movavg_norm #(
    parameter int unsigned WL     = movavg_pkg::WL,
    parameter int unsigned SHIFT  = movavg_pkg::TAP_LOG2,
    parameter int unsigned ROUND  = 1,
    parameter int unsigned WARMUP = movavg_pkg::WARMUP,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    movavg_norm_if.slave         io,
    output logic                 drop_flag,
    output movavg_pkg::drop_cnt_t drop_cnt
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [WL:0] RND =
        (ROUND != 0 && SHIFT > 0) ? ((WL + 1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;

    logic [WL:0]           sum_ext;
    logic [WL-1:0]         avg;
    logic [WW-1:0]         warm_q, warm_d;
    logic                  warm_done;
    logic                  push_req, pop, wr, drop;
    logic                  full;
    logic [CW-1:0]         count;
    logic                  drop_flag_q, drop_flag_d;
    movavg_pkg::drop_cnt_t drop_cnt_q, drop_cnt_d;

    // One extra bit so the rounding add cannot overflow before the shift.
    assign sum_ext = {1'b0, io.sum_in} + RND;
    assign avg     = WL'(sum_ext >> SHIFT);

    assign warm_done = (warm_q == WW'(WARMUP));
    assign push_req  = io.sum_valid && warm_done;
    assign pop       = io.dout_valid && io.dout_ready;
    assign wr        = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    always_comb begin
        warm_d      = warm_q;
        drop_flag_d = drop_flag_q;
        drop_cnt_d  = drop_cnt_q;
        if (io.sum_valid && !warm_done) begin
            warm_d = warm_q + WW'(1);
        end
        if (drop) begin
            drop_flag_d = 1'b1;
            drop_cnt_d  = movavg_pkg::sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_q      <= '0;
            drop_flag_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            warm_q      <= warm_d;
            drop_flag_q <= drop_flag_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    movavg_fifo #(
        .WL    (WL),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (wr),
        .pop_i   (pop),
        .wdata_i (avg),
        .rdata_o (io.dout),
        .full_o  (full),
        .count_o (count)
    );

    assign io.dout_valid = (count != '0);
    assign drop_flag     = drop_flag_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_movavg_norm.sv
// Scoreboard bench for movavg_norm. Two instances (ROUND=1 and ROUND=0)
// receive identical stimulus; each stimulus cycle pushes the hand-computed
// averages for accepted samples, and per-instance monitors compare at the
// falling edge whenever the DUT presents data.
module tb_movavg_norm;

    localparam int unsigned WL     = 64;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned WARMUP = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    movavg_norm_if #(.WL(WL)) ifr ();
    movavg_norm_if #(.WL(WL)) ift ();

    logic        flag_r, flag_t;
    logic [15:0] drop_r, drop_t;

    movavg_norm #(.WL(WL), .ROUND(1), .DEPTH(DEPTH)) dut_r (
        .clk       (clk),
        .reset_n   (reset_n),
        .io        (ifr),
        .drop_flag (flag_r),
        .drop_cnt  (drop_r)
    );

    movavg_norm #(.WL(WL), .ROUND(0), .DEPTH(DEPTH)) dut_t (
        .clk       (clk),
        .reset_n   (reset_n),
        .io        (ift),
        .drop_flag (flag_t),
        .drop_cnt  (drop_t)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] qr[$];
    logic [63:0] qt[$];
    int          occ  = 0;
    int          warm = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: expected valid follows the scoreboard occupancy.
    always @(negedge clk) begin
        if (reset_n) begin
            check("valid_r", ifr.dout_valid, qr.size() != 0);
            if (ifr.dout_valid && qr.size() != 0) begin
                check("dout_r", ifr.dout, qr[0]);
                if (ifr.dout_ready) void'(qr.pop_front());
            end else if (!ifr.dout_valid) begin
                check("dout_idle_r", ifr.dout, 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("valid_t", ift.dout_valid, qt.size() != 0);
            if (ift.dout_valid && qt.size() != 0) begin
                check("dout_t", ift.dout, qt[0]);
                if (ift.dout_ready) void'(qt.pop_front());
            end else if (!ift.dout_valid) begin
                check("dout_idle_t", ift.dout, 64'd0);
            end
        end
    end

    task automatic set_in(input bit v, input logic [63:0] d, input bit r);
        ifr.sum_valid = v;  ift.sum_valid = v;
        ifr.sum_in    = d;  ift.sum_in    = d;
        ifr.dout_ready = r; ift.dout_ready = r;
    endtask

    // One clock of stimulus; er/et are the hand-computed averages for d.
    task automatic drive(input bit v, input logic [63:0] d, input bit r,
                         input logic [63:0] er, input logic [63:0] et);
        bit pop;
        set_in(v, d, r);
        @(posedge clk);
        pop = (occ > 0) && r;
        if (v) begin
            if (warm < WARMUP) begin
                warm++;
            end else if (occ < DEPTH || pop) begin
                qr.push_back(er);
                qt.push_back(et);
                occ++;
            end
        end
        if (pop) occ--;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 64'd0, 1'b1, 64'd0, 64'd0);
    endtask

    // Asserted mid-cycle to exercise the asynchronous clear.
    task automatic mid_reset();
        set_in(1'b0, 64'd0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid_r", ifr.dout_valid, 1'b0);
        check("async_valid_t", ift.dout_valid, 1'b0);
        check("async_dout_r", ifr.dout, 64'd0);
        qr.delete();
        qt.delete();
        occ  = 0;
        warm = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_drop_cnt", drop_r, 16'd0);
        check("rst_drop_flag", flag_r, 1'b0);
    endtask

    initial begin
        set_in(1'b0, 64'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("reset_valid", ifr.dout_valid, 1'b0);
        check("reset_dout", ifr.dout, 64'd0);
        check("reset_drop_cnt", drop_r, 16'd0);
        check("reset_drop_flag", flag_r, 1'b0);

        // T1: warm-up samples vanish
        repeat (3) drive(1'b1, 64'd100, 1'b1, 64'd0, 64'd0);
        idle(1);
        check("t1_valid", ifr.dout_valid, 1'b0);
        check("t1_drop_cnt", drop_r, 16'd0);

        // T2: arithmetic, one-cycle latency
        drive(1'b1, 64'd10, 1'b1, 64'd3, 64'd2);
        check("t2_round", ifr.dout, 64'd3);
        check("t2_trunc", ift.dout, 64'd2);
        idle(1);
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'h4000_0000_0000_0000, 64'h3FFF_FFFF_FFFF_FFFF);
        check("t2_max_round", ifr.dout, 64'h4000_0000_0000_0000);
        check("t2_max_trunc", ift.dout, 64'h3FFF_FFFF_FFFF_FFFF);
        idle(1);

        // T3: overflow drops the newest samples
        for (int i = 1; i <= 6; i++) drive(1'b1, 64'(4 * i), 1'b0, 64'(i), 64'(i));
        check("t3_drop_cnt", drop_r, 16'd2);
        check("t3_drop_flag", flag_r, 1'b1);
        check("t3_drop_cnt_t", drop_t, 16'd2);
        idle(4);
        check("t3_empty", ifr.dout_valid, 1'b0);

        // T4: push and pop while full
        for (int i = 1; i <= 4; i++) drive(1'b1, 64'(4 * i), 1'b0, 64'(i), 64'(i));
        drive(1'b1, 64'd80, 1'b1, 64'd20, 64'd20);
        check("t4_valid", ifr.dout_valid, 1'b1);
        check("t4_drop_cnt", drop_r, 16'd2);
        idle(4);
        check("t4_empty", ifr.dout_valid, 1'b0);

        // T5: mid-stream reset, warm-up restarts
        drive(1'b1, 64'd28, 1'b0, 64'd7, 64'd7);
        drive(1'b1, 64'd32, 1'b0, 64'd8, 64'd8);
        drive(1'b1, 64'd36, 1'b0, 64'd9, 64'd9);
        mid_reset();
        repeat (3) drive(1'b1, 64'd100, 1'b1, 64'd0, 64'd0);
        idle(1);
        check("t5_warm_valid", ifr.dout_valid, 1'b0);
        drive(1'b1, 64'd40, 1'b1, 64'd10, 64'd10);
        check("t5_first", ifr.dout, 64'd10);
        idle(1);

        // T6: drop counter saturates
        for (int i = 1; i <= 4; i++) drive(1'b1, 64'(4 * i), 1'b0, 64'(i), 64'(i));
        repeat (65540) drive(1'b1, 64'd0, 1'b0, 64'd0, 64'd0);
        check("t6_sat_r", drop_r, 16'hFFFF);
        check("t6_sat_t", drop_t, 16'hFFFF);
        check("t6_flag", flag_r, 1'b1);
        idle(4);
        check("t6_empty", ifr.dout_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
